// File: rtl/clock_alarm_unit.sv
// clock_alarm_unit: alarm time comparator with self-timing ring and bounded snooze
module clock_alarm_unit #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZES = 3
) (
  input  logic                               Clk_1sec,
  input  logic                               reset,
  input  logic [4:0]                         hours,
  input  logic [5:0]                         minutes,
  input  logic [5:0]                         seconds,
  input  logic                               alarm_en,
  input  logic [4:0]                         alarm_hours,
  input  logic [5:0]                         alarm_minutes,
  input  logic                               snooze_req,
  input  logic                               stop_req,
  output logic                               alarm_out,
  output logic                               snoozing,
  output logic [$clog2(MAX_SNOOZES+1)-1:0]   snooze_count
);
  localparam int CW = $clog2(MAX_SNOOZES + 1);
  localparam int TW = $clog2((RING_SECS > SNOOZE_SECS ? RING_SECS : SNOOZE_SECS) + 1);
  localparam logic [TW-1:0] RING_LD = TW'(RING_SECS - 1);
  localparam logic [TW-1:0] SNZ_LD = TW'(SNOOZE_SECS - 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SNOOZES);
  localparam logic [1:0] IDLE = 2'b00, RING = 2'b01, SNOOZE = 2'b10;
  logic [1:0]    state;
  logic [TW-1:0] cnt;
  logic          match;
  always_comb match = alarm_en && hours == alarm_hours && minutes == alarm_minutes &&
                      seconds == 6'd0 && alarm_hours <= 5'd23 && alarm_minutes <= 6'd59;
  // state bits double as the registered outputs
  assign alarm_out = state[0];
  assign snoozing  = state[1];
  always_ff @(posedge Clk_1sec) begin
    if (!reset || !alarm_en || (state != IDLE && stop_req)) begin
      state        <= IDLE;
      cnt          <= '0;
      snooze_count <= '0;
    end else if (state == IDLE) begin
      if (match) begin
        state <= RING;
        cnt   <= RING_LD;
      end
    end else if (state == RING) begin
      if (snooze_req && snooze_count < MAX_CNT) begin
        state        <= SNOOZE;
        cnt          <= SNZ_LD;
        snooze_count <= snooze_count + CW'(1);
      end else if (cnt == '0) begin
        state        <= IDLE;
        snooze_count <= '0;
      end else begin
        cnt <= cnt - TW'(1);
      end
    end else if (state == SNOOZE) begin
      if (cnt == '0) begin
        state <= RING;
        cnt   <= RING_LD;
      end else begin
        cnt <= cnt - TW'(1);
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
